bitstream_writer: RTL
=====================

Name: bitstream_writer

Overview:
- AXI-stream master that serializes a parallel configuration word into the same bitstream format the fabric's configuration consumers read: LSB-first beats, with tlast on the final beat.
- Used by the configuration controller to drive LUT/routing config chains, and by the testbench as the stimulus source for config loading.
- Transmit-side counterpart of bitstream_reader.

Parameters:
- NUM_BITS_TO_WRITE, 8, total payload bits per transfer; must be ≥1.
- BEAT_WIDTH, 1, bits per stream beat; must equal the tdata width of the connected axi_stream_if.
- NUM_BEATS, ceil(NUM_BITS_TO_WRITE / BEAT_WIDTH), derived; not to be overridden.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; latches bits and begins a transfer
- bits  input  NUM_BITS_TO_WRITE  payload; sampled only in the cycle start is accepted
- bitstream  axi_stream_if.master  —  outgoing stream (tvalid, tready, tdata[BEAT_WIDTH], tlast)
- busy  output  1  high from the cycle after an accepted start until the final beat handshakes
- done  output  1  one-cycle pulse in the cycle after the final beat handshakes

Behaviour:
- Reset: asynchronous and active-high. All outputs reset to 0: tvalid, tlast, tdata, busy, done. Reset also clears the shift register and beat counter.
  - Reset mid-transfer aborts immediately. Not resumable. tvalid drops in the same cycle rst asserts.
- States: IDLE, SEND, DONE (enum, 2 bits).
- IDLE:
  - start=1 → latch bits into the shift register, zero-padded to NUM_BEATS*BEAT_WIDTH. Load beat counter = NUM_BEATS-1. Go to SEND.
  - start=0 → remain in IDLE.
- SEND:
  - tvalid=1. tdata = shift register [BEAT_WIDTH-1:0]. tlast = (beat counter == 0).
  - Handshake (tvalid & tready):
    - If not last: shift right by BEAT_WIDTH, decrement counter, stay in SEND.
    - If last: go to DONE.
  - No handshake: tdata, tlast, and tvalid hold stable (AXI rule; tvalid never deasserts without a handshake).
- DONE: done=1 for exactly one cycle, busy=0, tvalid=0. Unconditionally → IDLE.
- Latency:
  - start accepted at cycle N → first beat valid at N+1.
  - With tready held high, the final beat handshakes at N+NUM_BEATS and done pulses at N+NUM_BEATS+1.
  - Minimum start-to-start spacing is NUM_BEATS+2 cycles.
- Beat order: beat k carries bits[k*BEAT_WIDTH +: BEAT_WIDTH], k = 0..NUM_BEATS-1. Padding bits in the final partial beat are 0.
- start while in SEND or DONE is ignored. No queueing, and bits are not resampled.
- tready asserted while tvalid=0 has no effect.
- NUM_BEATS=1: a single beat with tlast=1 in the first SEND cycle.
- Beat counter width is $clog2(NUM_BEATS) with a minimum of 1. It must never underflow; the last-beat decision uses the ==0 compare.
- busy = (state == SEND). done = (state == DONE).

Decomposition:
- Shared config package (fpga_cfg_pkg):
  - function num_beats(num_bits, beat_width) returning the ceil division, also used by bitstream_reader for beat accounting.
  - Constant CFG_BEAT_WIDTH_DEFAULT = 1.
- State enum stays local to the module.
- No sub-module: the shift register, counter, and FSM are small enough to live inline.

Test Plan:
- NUM_BITS=8, BEAT_WIDTH=1, bits=8'hA5, tready=1 → tdata sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting N+1; tlast only on beat 8; done at N+9.
- NUM_BITS=10, BEAT_WIDTH=4, bits=10'h2F3, tready=1 → 3 beats: 4'h3, 4'hF, 4'h2 (upper 2 bits padded 0); tlast on beat 3.
- Back-pressure: same as the first scenario, tready low for 3 cycles at beat 4 → beat 4 tdata/tlast/tvalid held constant for 3 cycles; total sequence unchanged; done delayed by 3 cycles.
- start re-pulsed with bits=8'hFF during SEND of 8'hA5 → output stream remains 8'hA5; no second transfer follows.
- rst asserted asynchronously at beat 5 → tvalid, busy, and done = 0 immediately. After release, start with 8'h3C → a full 8-beat transfer of 8'h3C from beat 0.
- Loopback: bitstream_writer → bitstream_reader (NUM_BITS=16), random 16-bit words × 100, random tready → the reader's bits equal the written bits for every transfer.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration-fabric definitions for the bitstream writer and reader.
// Latency: none, it holds compile-time constants and helpers only.
// Backpressure: not applicable.
package fpga_cfg_pkg;

    // Default number of bits carried by each configuration stream beat.
    localparam int CFG_BEAT_WIDTH_DEFAULT = 1;

    // Number of beats needed to carry num_bits, rounding up to a whole beat.
    function automatic int num_beats(input int num_bits, input int beat_width);
        return (num_bits + beat_width - 1) / beat_width;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle carrying configuration beats.
// Latency: none, it is wires only.
// Backpressure: the slave controls tready, and the master holds a beat until tvalid & tready.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 1
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/bitstream_writer.sv
// Serializes a parallel config word into LSB-first stream beats and marks the last beat with tlast.
// Latency: first beat is valid 1 cycle after start, and done pulses 1 cycle after the last handshake.
// Backpressure: beats are held stable while tready is low, and start is ignored while busy.
module bitstream_writer
    import fpga_cfg_pkg::*;
#(
    parameter  int NUM_BITS_TO_WRITE = 8,
    parameter  int BEAT_WIDTH        = CFG_BEAT_WIDTH_DEFAULT,
    localparam int NUM_BEATS         = num_beats(NUM_BITS_TO_WRITE, BEAT_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_BITS_TO_WRITE-1:0] bits,
    axi_stream_if.master                 bitstream,
    output logic                         busy,
    output logic                         done
);

    // The shift register is padded to whole beats so the final partial beat shifts in zeros.
    localparam int SR_W  = NUM_BEATS * BEAT_WIDTH;
    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_beat;
    logic              beat_hs;

    // The counter counts down to zero and is never decremented past it, so zero marks the final beat.
    assign last_beat = (cnt_q == '0);
    assign beat_hs   = (state_q == ST_SEND) && bitstream.tready;

    // State, shift register and beat counter. Reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: latch on start, advance one beat per handshake, then spend one cycle in DONE.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = SR_W'(bits);
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_hs) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        sr_d  = sr_q >> BEAT_WIDTH;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so tvalid drops as soon as reset asserts.
    always_comb begin
        bitstream.tvalid = (state_q == ST_SEND);
        bitstream.tlast  = (state_q == ST_SEND) && last_beat;
        bitstream.tdata  = (state_q == ST_SEND) ? sr_q[BEAT_WIDTH-1:0] : '0;
        busy             = (state_q == ST_SEND);
        done             = (state_q == ST_DONE);
    end

endmodule
